fwd_hazard_unit: RTL

//  Producer side of the EX-stage bypass interface. Holds the EX/MEM and MEM/WB

---
 rtl/fwd_hazard_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage bypass producer: EX/MEM and MEM/WB pipeline registers, operand
// forwarding select generation, load-use stall detection and a saturating
// stall-cycle counter.
module fwd_hazard_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RAW   = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RAW-1:0]   id_rs1,
  input  logic [RAW-1:0]   id_rs2,
  input  logic [RAW-1:0]   ex_rs1,
  input  logic [RAW-1:0]   ex_rs2,
  input  logic [RAW-1:0]   ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_flush,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  mem_read_data,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [XLEN-1:0]  ALUResult_MEM,
  output logic [XLEN-1:0]  WriteData_WB,
  output logic [RAW-1:0]   wb_rd,
  output logic             wb_reg_write,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // EX/MEM register
  logic [RAW-1:0]   mem_rd_q, mem_rd_d;
  logic             mem_reg_write_q, mem_reg_write_d;
  logic             mem_mem_read_q, mem_mem_read_d;
  logic [XLEN-1:0]  mem_alu_q, mem_alu_d;

  // MEM/WB register
  logic [RAW-1:0]   wb_rd_q, wb_rd_d;
  logic             wb_reg_write_q, wb_reg_write_d;
  logic             wb_mem_read_q, wb_mem_read_d;
  logic [XLEN-1:0]  wb_alu_q, wb_alu_d;
  logic [XLEN-1:0]  wb_read_data_q, wb_read_data_d;

  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  fwd_sel_e fwd_a, fwd_b;
  logic     stall_c;

  // Pipeline advance: a flushed EX instruction travels on as a bubble with
  // its write/load qualifiers cleared.
  always_comb begin
    mem_rd_d        = ex_rd;
    mem_reg_write_d = ex_reg_write & ~ex_flush;
    mem_mem_read_d  = ex_mem_read & ~ex_flush;
    mem_alu_d       = ex_alu_result;
    wb_rd_d         = mem_rd_q;
    wb_reg_write_d  = mem_reg_write_q;
    wb_mem_read_d   = mem_mem_read_q;
    wb_alu_d        = mem_alu_q;
    wb_read_data_d  = mem_read_data;
  end

  // Forwarding select: MEM beats WB; x0 and loads still in MEM never bypass.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_reg_write_q && !mem_mem_read_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs1))
      fwd_a = FWD_MEM;
    else if (wb_reg_write_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs1))
      fwd_a = FWD_WB;
    if (mem_reg_write_q && !mem_mem_read_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs2))
      fwd_b = FWD_MEM;
    else if (wb_reg_write_q && (wb_rd_q != '0) && (wb_rd_q == ex_rs2))
      fwd_b = FWD_WB;
  end

  // Load-use detection against the instruction in ID; a flush suppresses it.
  always_comb begin
    stall_c = ex_mem_read & ex_reg_write & ~ex_flush & (ex_rd != '0) &
              ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end

  // Stall-cycle counter, holds at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_c && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      mem_alu_q       <= '0;
      wb_rd_q         <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_read_q   <= 1'b0;
      wb_alu_q        <= '0;
      wb_read_data_q  <= '0;
      stall_count_q   <= '0;
    end else begin
      mem_rd_q        <= mem_rd_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_mem_read_q  <= mem_mem_read_d;
      mem_alu_q       <= mem_alu_d;
      wb_rd_q         <= wb_rd_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_read_q   <= wb_mem_read_d;
      wb_alu_q        <= wb_alu_d;
      wb_read_data_q  <= wb_read_data_d;
      stall_count_q   <= stall_count_d;
    end
  end

  // Output drive and writeback value selection.
  always_comb begin
    ForwardA      = fwd_a;
    ForwardB      = fwd_b;
    ALUResult_MEM = mem_alu_q;
    WriteData_WB  = wb_mem_read_q ? wb_read_data_q : wb_alu_q;
    wb_rd         = wb_rd_q;
    wb_reg_write  = wb_reg_write_q;
    stall         = stall_c;
    stall_count   = stall_count_q;
  end

endmodule
